alu_share_arbiter: RTL and testbench

Two-port arbiter that shares the single ALU datapath (ALU_Control plus ALU) between two requesters, e.g. the execute stage and a multi-cycle helper unit. It accepts one operation at a time over a valid/ready handshake and latches the operands, FuncCode and ALU_op. It drives the shared ALU for exactly one cycle, captures the result and zero flag, and returns them to the winning requester over a valid/ready response channel.

---
 rtl/alu_share_arbiter.sv | 159 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU (ALU_Control + ALU) between two requesters.
// Ports: clk, reset (async, active-high); req0/req1 valid/ready + a, b, func, aluop;
// alu_a/alu_b/alu_func/alu_op drive the shared ALU, alu_result/alu_zero return from it;
// rsp0/rsp1 valid/ready with shared rsp_result/rsp_zero; busy = FSM not IDLE.
// Define ALU_ARB_RR_EN for round-robin arbitration (default: port 0 fixed priority).
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [5:0]       req0_func,
  input  logic [5:0]       req1_func,
  input  logic [1:0]       req0_aluop,
  input  logic [1:0]       req1_aluop,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [5:0]       alu_func,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  input  logic             rsp0_ready,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [5:0]       func_q;
  logic [1:0]       op_q;
  logic             port_q;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;

  logic gnt1;
  logic req_fire;
  logic rsp_fire;

`ifdef ALU_ARB_RR_EN
  // ptr_q names the preferred port on a tie; a sole requester always wins.
  logic ptr_q;

  assign gnt1 = req1_valid && (!req0_valid || ptr_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else if (req_fire) begin
      ptr_q <= ~gnt1;
    end
  end
`else
  assign gnt1 = req1_valid && !req0_valid;
`endif

  assign req_fire = req0_ready || req1_ready;

  always_comb begin
    rsp_fire = 1'b0;
    if (state_q == RESP) begin
      rsp_fire = port_q ? rsp1_ready : rsp0_ready;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req_fire) state_d = EXEC;
      EXEC: state_d = RESP;
      RESP: if (rsp_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs; readies are also masked by reset so they drop immediately.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    busy       = 1'b1;
    unique case (state_q)
      IDLE: begin
        busy       = 1'b0;
        req0_ready = !reset && req0_valid && !gnt1;
        req1_ready = !reset && gnt1;
      end
      EXEC: ;
      RESP: begin
        rsp0_valid = !port_q;
        rsp1_valid = port_q;
      end
      default: busy = 1'b0;
    endcase
  end

  // Operand and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      func_q <= '0;
      op_q   <= '0;
      port_q <= 1'b0;
      res_q  <= '0;
      zero_q <= 1'b0;
    end else begin
      if (req_fire) begin
        port_q <= req1_ready;
        a_q    <= req1_ready ? req1_a : req0_a;
        b_q    <= req1_ready ? req1_b : req0_b;
        func_q <= req1_ready ? req1_func : req0_func;
        op_q   <= req1_ready ? req1_aluop : req0_aluop;
      end
      if (state_q == EXEC) begin
        res_q  <= alu_result;
        zero_q <= alu_zero;
      end
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_func   = func_q;
  assign alu_op     = op_q;
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: self-checking bench for alu_share_arbiter.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_alu_share_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0_valid = 0, req1_valid = 0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [5:0]   req0_func = '0, req1_func = '0;
  logic [1:0]   req0_aluop = '0, req1_aluop = '0;
  logic [W-1:0] alu_a, alu_b;
  logic [5:0]   alu_func;
  logic [1:0]   alu_op;
  logic [W-1:0] alu_result;
  logic         alu_zero;
  logic         rsp0_valid, rsp1_valid;
  logic         rsp0_ready = 1, rsp1_ready = 1;
  logic [W-1:0] rsp_result;
  logic         rsp_zero;
  logic         busy;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_func(req0_func), .req1_func(req1_func),
    .req0_aluop(req0_aluop), .req1_aluop(req1_aluop),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy)
  );

  // Combinational ALU standing in for ALU_Control + ALU
  always_comb begin
    alu_result = '0;
    if (alu_op == 2'b00) alu_result = alu_a + alu_b;
    else if (alu_op == 2'b01) alu_result = alu_a - alu_b;
    else begin
      case (alu_func)
        6'b100000: alu_result = alu_a + alu_b;
        6'b100010: alu_result = alu_a - alu_b;
        6'b100100: alu_result = alu_a & alu_b;
        6'b100101: alu_result = alu_a | alu_b;
        6'b101010: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 1 : 0;
        default:   alu_result = '0;
      endcase
    end
    alu_zero = (alu_result == '0);
  end

  typedef struct {
    bit           port;
    logic [W-1:0] res;
    bit           zero;
  } exp_t;

  typedef struct {
    bit           port;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [5:0]   func;
    logic [1:0]   op;
    logic [W-1:0] res;
    bit           zero;
  } vec_t;

  exp_t sb[$];
  exp_t cur0, cur1;
  int   grant_q[$];
  int   gcyc_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Scoreboard: push on request handshake, pop on response handshake
  always @(negedge clk) begin
    if (!reset) begin
      if (req0_valid && req0_ready) begin
        sb.push_back(cur0); grant_q.push_back(0); gcyc_q.push_back(cyc);
      end
      if (req1_valid && req1_ready) begin
        sb.push_back(cur1); grant_q.push_back(1); gcyc_q.push_back(cyc);
      end
      if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
        chk("rsp_onehot", {31'd0, rsp0_valid && rsp1_valid}, 0);
        if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_port", {31'd0, rsp1_valid}, {31'd0, e.port});
          chk("rsp_result", rsp_result, e.res);
          chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.zero});
        end
      end
    end
  end

  task automatic drive(input bit p, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [5:0] f, input logic [1:0] op,
                       input logic [W-1:0] r, input bit z);
    if (!p) begin
      req0_a = a; req0_b = b; req0_func = f; req0_aluop = op;
      cur0 = '{1'b0, r, z}; req0_valid = 1;
    end else begin
      req1_a = a; req1_b = b; req1_func = f; req1_aluop = op;
      cur1 = '{1'b1, r, z}; req1_valid = 1;
    end
  endtask

  // Drive a request, wait for its handshake, drop valid (now in EXEC).
  task automatic issue(input bit p, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [5:0] f, input logic [1:0] op,
                       input logic [W-1:0] r, input bit z);
    int n;
    @(posedge clk); #1;
    drive(p, a, b, f, op, r, z);
    n = 0;
    @(negedge clk);
    while (!(p ? req1_ready : req0_ready) && n < 20) begin
      @(negedge clk); n++;
    end
    if (!(p ? req1_ready : req0_ready)) chk("grant_timeout", 0, 1);
    @(posedge clk); #1;
    if (!p) req0_valid = 0; else req1_valid = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 50) begin
      @(negedge clk); n++;
    end
    if (sb.size() != 0 || busy) chk("drain_timeout", 1, 0);
  endtask

  task automatic wait_grants(input int k);
    int n;
    n = 0;
    while (grant_q.size() < k && n < 80) begin
      @(negedge clk); n++;
    end
    if (grant_q.size() < k) chk("grants_timeout", grant_q.size(), k);
  endtask

  vec_t vecs[7];

  initial begin
    int ord[4];
    logic [W-1:0] held;
`ifdef ALU_ARB_RR_EN
    ord = '{0, 1, 0, 1};
`else
    ord = '{0, 0, 0, 0};
`endif
    vecs[0] = '{0, 32'd5, 32'd3, 6'b100000, 2'b10, 32'd8, 0};
    vecs[1] = '{1, 32'd7, 32'd7, 6'b100010, 2'b10, 32'd0, 1};
    vecs[2] = '{0, 32'hF0, 32'h3C, 6'b100100, 2'b10, 32'h30, 0};
    vecs[3] = '{1, 32'hF0, 32'h0F, 6'b100101, 2'b10, 32'hFF, 0};
    vecs[4] = '{0, 32'd3, 32'd5, 6'b101010, 2'b10, 32'd1, 0};
    vecs[5] = '{1, 32'd3, 32'd5, 6'b100010, 2'b10, 32'hFFFF_FFFE, 0};
    vecs[6] = '{0, 32'hFFFF_FFFF, 32'd1, 6'b100000, 2'b10, 32'd0, 1};

    // Reset state
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ready", {30'd0, req1_ready, req0_ready}, 0);
    chk("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_rsp_result", rsp_result, 0);
    req0_valid = 0; req1_valid = 0;
    @(posedge clk); @(posedge clk); #1;
    reset = 0;

    // Single op on port 0 with cycle-exact checks
    @(posedge clk); #1;
    drive(0, 32'd5, 32'd3, 6'b100000, 2'b10, 32'd8, 0);
    @(negedge clk);
    chk("t1_ready0", {31'd0, req0_ready}, 1);
    chk("t1_ready1", {31'd0, req1_ready}, 0);
    @(posedge clk); #1;
    req0_valid = 0;
    @(negedge clk);
    chk("t1_exec_busy", {31'd0, busy}, 1);
    chk("t1_alu_a", alu_a, 5);
    chk("t1_alu_b", alu_b, 3);
    chk("t1_alu_func", {26'd0, alu_func}, 32'h20);
    chk("t1_alu_op", {30'd0, alu_op}, 2);
    chk("t1_exec_rsp0", {31'd0, rsp0_valid}, 0);
    @(negedge clk);
    chk("t1_rsp0_valid", {31'd0, rsp0_valid}, 1);
    chk("t1_rsp_result", rsp_result, 8);
    @(negedge clk);
    chk("t1_busy_clear", {31'd0, busy}, 0);

    // Table-driven vectors
    for (int i = 0; i < 7; i++) begin
      issue(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].func, vecs[i].op,
            vecs[i].res, vecs[i].zero);
      drain();
    end

    // Response backpressure with port 1 pending
    rsp0_ready = 0;
    issue(0, 32'd9, 32'd1, 6'b100000, 2'b10, 32'd10, 0);
    drive(1, 32'd2, 32'd2, 6'b100000, 2'b10, 32'd4, 0);
    @(negedge clk);
    chk("bp_exec_ready1", {31'd0, req1_ready}, 0);
    held = 32'd10;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_rsp0_valid", {31'd0, rsp0_valid}, 1);
      chk("bp_result_stable", rsp_result, held);
      chk("bp_busy", {31'd0, busy}, 1);
      chk("bp_ready1", {31'd0, req1_ready}, 0);
    end
    @(posedge clk); #1;
    rsp0_ready = 1;
    @(negedge clk);
    chk("bp_ready1_same", {31'd0, req1_ready}, 0);
    @(negedge clk);
    chk("bp_ready1_next", {31'd0, req1_ready}, 1);
    @(posedge clk); #1;
    req1_valid = 0;
    drain();

    // Contention: both ports valid continuously
    grant_q.delete();
    @(posedge clk); #1;
    drive(0, 32'd1, 32'd1, 6'b100000, 2'b10, 32'd2, 0);
    drive(1, 32'd2, 32'd2, 6'b100000, 2'b10, 32'd4, 0);
    wait_grants(4);
    @(posedge clk); #1;
    req0_valid = 0;
`ifdef ALU_ARB_RR_EN
    req1_valid = 0;
`else
    wait_grants(5);
    @(posedge clk); #1;
    req1_valid = 0;
    if (grant_q.size() >= 5) chk("cont_late_grant", grant_q[4], 1);
`endif
    drain();
    for (int k = 0; k < 4; k++) begin
      if (k < grant_q.size()) chk("cont_order", grant_q[k], ord[k]);
    end

    // Reset during EXEC discards the operation
    issue(0, 32'd4, 32'd4, 6'b100000, 2'b10, 32'd8, 0);
    req1_valid = 1;
    reset = 1;
    #1;
    chk("mr_busy", {31'd0, busy}, 0);
    chk("mr_alu_a", alu_a, 0);
    chk("mr_alu_b", alu_b, 0);
    chk("mr_rsp_result", rsp_result, 0);
    chk("mr_ready", {30'd0, req1_ready, req0_ready}, 0);
    chk("mr_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 0);
    sb.delete();
    @(posedge clk); @(posedge clk); #1;
    reset = 0; req1_valid = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mr_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 0);
    end
    issue(0, 32'd6, 32'd1, 6'b100010, 2'b10, 32'd5, 0);
    drain();

    // Back-to-back on port 0
    grant_q.delete();
    gcyc_q.delete();
    @(posedge clk); #1;
    drive(0, 32'd10, 32'd20, 6'b100000, 2'b10, 32'd30, 0);
    wait_grants(3);
    @(posedge clk); #1;
    req0_valid = 0;
    drain();
    if (gcyc_q.size() >= 3) begin
      chk("b2b_gap1", gcyc_q[1] - gcyc_q[0], 3);
      chk("b2b_gap2", gcyc_q[2] - gcyc_q[1], 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
